// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one 16x16 shift-add multiplier core between NUM_REQ
// requesters: captures operands, pulses the core's init, waits for done under a watchdog.
module mult_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_pp,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    m_init,
  output logic [15:0]             m_A,
  output logic [15:0]             m_B,
  input  logic [31:0]             m_pp,
  input  logic                    m_done
);

  localparam int DATA_W = 16;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W   = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_GUARD = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] next_ptr;
  logic             pick_vld;
  logic [IDX_W:0]   pick;
  logic [WD_W-1:0]  wd_cnt;

  // First valid requester scanning upward from ptr with wrap; returns {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                             input logic [IDX_W-1:0]   ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && vld[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  assign pick      = rr_pick(req_valid, rr_ptr);
  assign pick_vld  = pick[IDX_W];
  assign pick_idx  = pick[IDX_W-1:0];
  assign next_ptr  = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  assign m_init    = (state == S_START);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP) ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      wd_cnt    <= '0;
      req_ready <= '0;
      rsp_pp    <= '0;
      rsp_err   <= 1'b0;
      m_A       <= '0;
      m_B       <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            m_A       <= req_a[DATA_W*pick_idx +: DATA_W];
            m_B       <= req_b[DATA_W*pick_idx +: DATA_W];
            req_ready <= NUM_REQ'(1) << pick_idx;
            gnt_idx   <= pick_idx;
            rr_ptr    <= next_ptr;
            state     <= S_START;
          end
        end
        S_START: begin
          wd_cnt <= '0;
          state  <= S_GUARD;
        end
        // done may still be high from the previous product; skip one cycle before sampling it
        S_GUARD: state <= S_WAIT;
        S_WAIT: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          if (m_done) begin
            rsp_pp  <= m_pp;
            rsp_err <= 1'b0;
            state   <= S_RESP;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            rsp_pp  <= '0;
            rsp_err <= 1'b1;
            state   <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one 16x16 shift-add multiplier core (`init`/`A`/`B`/`pp`/`done` interface) between NUM_REQ requesters.
- Requesters are typically CPU-side peripheral ports or accelerator lanes on the femtoRV bus.
- Round-robin arbitration; captures operands; sequences the core's `init` pulse; waits for `done`, with a watchdog timeout.
- Returns the 32-bit product to the granted requester with a one-cycle response strobe.

Parameters:
- NUM_REQ, 2, number of requesters (legal range 2..4).
- TIMEOUT, 64, max cycles in WAIT before abort (must be ≥ 40, above the core's worst-case 16-bit latency).

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, NUM_REQ, request i pending.
- req_a, input, 16*NUM_REQ, operand A of requester i in bits [16i+15:16i].
- req_b, input, 16*NUM_REQ, operand B of requester i in bits [16i+15:16i].
- req_ready, output, NUM_REQ, one-cycle pulse: operands of requester i captured.
- rsp_valid, output, NUM_REQ, one-cycle pulse: result for requester i on rsp_pp.
- rsp_pp, output, 32, product of the last completed operation; held until the next completion.
- rsp_err, output, 1, qualifies rsp_valid; 1 = watchdog timeout, rsp_pp = 0.
- busy, output, 1, high in any state except IDLE.
- m_init, output, 1, to core `init`.
- m_A, output, 16, to core `A`; registered, stable from START until IDLE.
- m_B, output, 16, to core `B`; registered, stable from START until IDLE.
- m_pp, input, 32, from core `pp`.
- m_done, input, 1, from core `done` (level).

Behaviour:
- Reset (rst=1 at the clock edge, in any state):
  - state=IDLE, rr_ptr=0, wd_cnt=0.
  - req_ready=0, rsp_valid=0, rsp_err=0, rsp_pp=0, m_init=0, m_A=0, m_B=0, busy=0.
  - The core shares rst, so an in-flight multiply is abandoned with no response.
- State IDLE:
  - If any req_valid: grant g = first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Latch m_A/m_B from slice g; pulse req_ready[g] for that one cycle.
  - Store g; rr_ptr <= (g+1) mod NUM_REQ; go to START.
  - Otherwise stay in IDLE.
- State START: m_init=1 for exactly one cycle; wd_cnt <= 0; go to GUARD.
- State GUARD (one cycle):
  - m_done is ignored, because the core's `done` can still be high from the previous operation.
  - Go to WAIT.
- State WAIT:
  - wd_cnt increments each cycle.
  - If m_done=1: rsp_pp <= m_pp, rsp_err <= 0, go to RESP.
  - Else if wd_cnt == TIMEOUT-1: rsp_pp <= 0, rsp_err <= 1, go to RESP.
  - If both conditions hold in the same cycle, m_done wins.
- State RESP: rsp_valid[g]=1 for one cycle (rsp_err valid alongside); go to IDLE.
- Latency:
  - req_valid high in IDLE → req_ready next edge.
  - rsp_valid appears 3 + core_latency cycles after req_ready.
  - Minimum spacing between grants is 4 + core_latency cycles.
- Requester handshake:
  - Requester must hold req_valid and operands stable until it sees req_ready.
  - req_valid dropping before grant withdraws the request with no side effect.
  - A requester may re-assert req_valid the cycle after req_ready; it is queued behind the others by round-robin.
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0...
  - No requester waits more than NUM_REQ-1 other operations.
- Simultaneous events:
  - New req_valid during START/GUARD/WAIT/RESP is not sampled until IDLE.
  - At most one req_ready bit and one rsp_valid bit is high in any cycle.
- Arithmetic: unsigned 16x16 → 32. Operand 0 is legal; the core may raise done early, and the arbiter accepts it.
- m_init never asserts outside START. m_A/m_B never change between START and RESP.

Test Plan:
- Single request: req 0 with A=0x0003, B=0x0005 → req_ready[0] pulse; then one m_init pulse; then rsp_valid[0] with rsp_pp=0x0000000F, rsp_err=0, busy low the cycle after.
- Max operands: A=0xFFFF, B=0xFFFF on req 1 → rsp_pp=0xFFFE0001 on rsp_valid[1] only.
- Contention: reqs 0 and 1 valid continuously, each with A=2, B=k → grants alternate 0,1,0,1 starting at 0; four responses with correct products; no overlap of ready/valid bits.
- Timeout: stub core holds m_done=0 → exactly TIMEOUT cycles after GUARD, rsp_valid[g]=1, rsp_err=1, rsp_pp=0; return to IDLE.
- Stale done: stub core keeps m_done=1 from the previous operation through GUARD → not accepted in GUARD; accepted in the first WAIT cycle where sampled high. Check no response is issued before WAIT.
- Reset mid-operation: assert rst during WAIT → next cycle all outputs 0, state IDLE, no rsp_valid; the next request is granted to requester 0 (rr_ptr=0).
